// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: active-low row sense in, column drive and key events out.
// master is the scanner side, slave is the keypad / front-panel side.
interface keypad_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int KW = $clog2(ROWS * COLS);

  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [KW-1:0]   key_code;
  logic            key_down;
  logic            press_pulse;
  logic            release_pulse;
  logic            multi_key;

  modport master (
    input  row_n,
    output col_n, key_code, key_down, press_pulse, release_pulse, multi_key
  );

  modport slave (
    output row_n,
    input  col_n, key_code, key_down, press_pulse, release_pulse, multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// ROWS x COLS matrix keypad scanner with frame debounce and ghost rejection.
// Define KEYPAD_REPEAT_EN to add auto-repeat press pulses for a held key.
module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  localparam int KW          = $clog2(ROWS * COLS)
) (
  input logic             clk,
  input logic             reset,
  keypad_scanner_if.master kp
);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [3:0]    DEB        = 4'(DEBOUNCE);

  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < 4 ||
      DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gParamCheck
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SCAN, EVAL} state_t;

  state_t          state_q;
  logic [ROWS-1:0] rowMeta_q, rowSync_q;
  logic [CW-1:0]   colIdx_q;
  logic [DW-1:0]   dwell_q;
  logic [1:0]      hits_q, prevHits_q;
  logic [KW-1:0]   hitCode_q, prevCode_q, comKey_q, pendCode_q;
  logic [3:0]      matchCnt_q;
  logic            comValid_q, pendPress_q;
  logic [COLS-1:0] colN_q;
  logic [KW-1:0]   keyCode_q;
  logic            keyDown_q, pressPulse_q, releasePulse_q, multiKey_q;

  logic [3:0]      colLowCnt, matchCnt_d;
  logic [KW-1:0]   colLowCode, hitCode_d;
  logic [1:0]      hits_d;
  logic            sameAsPrev, differs, commitNow, repFire;

  // hits counts closed switches in the frame so far, saturating at 2 (MULTI)
  always_comb begin
    colLowCnt  = '0;
    colLowCode = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!rowSync_q[r]) begin
        colLowCnt  = colLowCnt + 4'd1;
        colLowCode = KW'(r * COLS + int'(colIdx_q));
      end
    end
    hits_d    = hits_q;
    hitCode_d = hitCode_q;
    if (colLowCnt == 4'd1 && hits_q == 2'd0) begin
      hits_d    = 2'd1;
      hitCode_d = colLowCode;
    end else if (colLowCnt != 4'd0) begin
      hits_d = 2'd2;
    end

    sameAsPrev = (hits_q == prevHits_q) && (hits_q != 2'd1 || hitCode_q == prevCode_q);
    matchCnt_d = !sameAsPrev ? 4'd1 : ((matchCnt_q >= DEB) ? DEB : matchCnt_q + 4'd1);
    differs    = (hits_q == 2'd0) ? comValid_q : (!comValid_q || comKey_q != hitCode_q);
    commitNow  = (hits_q != 2'd2) && (matchCnt_d == DEB) && differs;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [RW-1:0] repCnt_q, repCnt_d;
  logic          repArmed_q;

  always_comb begin
    repCnt_d = repCnt_q + 1'b1;
    repFire  = 1'b0;
    if (state_q == EVAL && comValid_q && !commitNow && hits_q != 2'd2)
      repFire = repArmed_q ? (repCnt_d == RW'(REPEAT_RATE)) : (repCnt_d == RW'(REPEAT_DELAY));
  end

  // Frames since the last commit or press pulse; armed after the first repeat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      repCnt_q   <= '0;
      repArmed_q <= 1'b0;
    end else if (state_q == EVAL) begin
      if (commitNow || hits_q == 2'd2) begin
        repCnt_q   <= '0;
        repArmed_q <= 1'b0;
      end else if (comValid_q) begin
        if (repFire) begin
          repCnt_q   <= '0;
          repArmed_q <= 1'b1;
        end else begin
          repCnt_q <= repCnt_d;
        end
      end
    end
  end
`else
  assign repFire = 1'b0;
`endif

  // Scan/eval FSM; a key-to-key change defers the press by one cycle via pendPress_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      rowMeta_q      <= '1;
      rowSync_q      <= '1;
      colIdx_q       <= '0;
      dwell_q        <= '0;
      hits_q         <= '0;
      hitCode_q      <= '0;
      prevHits_q     <= '0;
      prevCode_q     <= '0;
      matchCnt_q     <= '0;
      comValid_q     <= 1'b0;
      comKey_q       <= '0;
      pendPress_q    <= 1'b0;
      pendCode_q     <= '0;
      colN_q         <= '1;
      keyCode_q      <= '0;
      keyDown_q      <= 1'b0;
      pressPulse_q   <= 1'b0;
      releasePulse_q <= 1'b0;
      multiKey_q     <= 1'b0;
    end else begin
      rowMeta_q      <= kp.row_n;
      rowSync_q      <= rowMeta_q;
      pressPulse_q   <= 1'b0;
      releasePulse_q <= 1'b0;
      if (pendPress_q) begin
        pendPress_q  <= 1'b0;
        pressPulse_q <= 1'b1;
        keyCode_q    <= pendCode_q;
        keyDown_q    <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          state_q  <= SCAN;
          colIdx_q <= '0;
          dwell_q  <= '0;
          colN_q   <= ~COLS'(1);
        end
        SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_q   <= '0;
            hits_q    <= hits_d;
            hitCode_q <= hitCode_d;
            if (colIdx_q == COL_LAST) begin
              state_q <= EVAL;
              colN_q  <= '1;
            end else begin
              colIdx_q <= colIdx_q + 1'b1;
              colN_q   <= ~(COLS'(1) << (colIdx_q + 1'b1));
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        EVAL: begin
          state_q    <= SCAN;
          colIdx_q   <= '0;
          colN_q     <= ~COLS'(1);
          hits_q     <= '0;
          multiKey_q <= (hits_q == 2'd2);
          if (hits_q == 2'd2) begin
            matchCnt_q <= '0;
            prevHits_q <= 2'd2;
          end else begin
            matchCnt_q <= matchCnt_d;
            prevHits_q <= hits_q;
            prevCode_q <= hitCode_q;
          end
          if (commitNow) begin
            comValid_q <= (hits_q == 2'd1);
            comKey_q   <= hitCode_q;
            if (hits_q == 2'd1 && !comValid_q) begin
              pressPulse_q <= 1'b1;
              keyCode_q    <= hitCode_q;
              keyDown_q    <= 1'b1;
            end else begin
              releasePulse_q <= 1'b1;
              keyDown_q      <= 1'b0;
              if (hits_q == 2'd1) begin
                pendPress_q <= 1'b1;
                pendCode_q  <= hitCode_q;
              end
            end
          end
          if (repFire) pressPulse_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kp.col_n         = colN_q;
  assign kp.key_code      = keyCode_q;
  assign kp.key_down      = keyDown_q;
  assign kp.press_pulse   = pressPulse_q;
  assign kp.release_pulse = releasePulse_q;
  assign kp.multi_key     = multiKey_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus a randomized
// frame-level run against a debounce reference model.
module tb_keypad_scanner;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  rowDrive;
  int checks = 0;
  int errors = 0;
  int pressSeen = 0, relSeen = 0, swapSeen = 0, overlapSeen = 0;
  bit relPrev = 1'b0;

  keypad_scanner_if #(.ROWS(4), .COLS(4)) kp();

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(DEB),
    .REPEAT_DELAY(2), .REPEAT_RATE(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kp)
  );

  always #5 clk = ~clk;

  // Ideal diode matrix: a row reads low when a closed key sits on a driven column
  always_comb begin
    rowDrive = '1;
    for (int r = 0; r < 4; r++) rowDrive[r] = ~|(keys[r*4 +: 4] & ~kp.col_n);
  end
  assign kp.row_n = rowDrive;

  always @(negedge clk) begin
    if (kp.press_pulse === 1'b1) begin
      pressSeen++;
      if (relPrev) swapSeen++;
    end
    if (kp.release_pulse === 1'b1) relSeen++;
    if (kp.press_pulse === 1'b1 && kp.release_pulse === 1'b1) overlapSeen++;
    relPrev = (kp.release_pulse === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearSeen();
    pressSeen = 0; relSeen = 0; swapSeen = 0; overlapSeen = 0;
  endtask

  task automatic waitEval();
    int n;
    n = 0;
    tick();
    while (kp.col_n !== 4'hF && n < 40) begin
      tick();
      n++;
    end
    if (kp.col_n !== 4'hF) begin
      checks++; errors++;
      $display("[TB] FAIL waitEval timeout: col_n=%b required 1111", kp.col_n);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    keys  = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] expCol;
    reset = 1'b1;
    keys  = '0;
    tick();
    checks++;
    if ({kp.col_n, kp.key_code, kp.key_down, kp.press_pulse, kp.release_pulse, kp.multi_key} !== {4'hF, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_state: col_n=%b code=%0d down=%b pr=%b rel=%b multi=%b required 1111/0",
               kp.col_n, kp.key_code, kp.key_down, kp.press_pulse, kp.release_pulse, kp.multi_key);
    end
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      expCol = (i < 16) ? ~(4'b0001 << (i / 4)) : 4'hF;
      checks++;
      if (kp.col_n !== expCol) begin
        errors++;
        $display("[TB] FAIL scan_cycle %0d: col_n=%b required %b", i + 1, kp.col_n, expCol);
      end
      checks++;
      if ({kp.key_code, kp.key_down, kp.press_pulse, kp.release_pulse, kp.multi_key} !== 8'h00) begin
        errors++;
        $display("[TB] FAIL idle_outputs cycle %0d: got %b required 0", i + 1,
                 {kp.key_code, kp.key_down, kp.press_pulse, kp.release_pulse, kp.multi_key});
      end
    end
  endtask

  task automatic test_press_release();
    int off, lat;
    waitEval();
    off = $urandom_range(0, 6);
    if (off > 0) off = off + 10;
    repeat (off) tick();
    keys[6] = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (kp.press_pulse !== 1'b1 && lat < 120);
    checks++;
    if (kp.press_pulse !== 1'b1 || lat < 51 || lat > 68) begin
      errors++;
      $display("[TB] FAIL press_latency: %0d cycles (pulse=%b) required 51..68", lat, kp.press_pulse);
    end
    tick();
    checks++;
    if (kp.key_code !== 4'd6 || kp.key_down !== 1'b1) begin
      errors++;
      $display("[TB] FAIL press_state: code=%0d down=%b required 6/1", kp.key_code, kp.key_down);
    end
    clearSeen();
    repeat (15) tick();
    checks++;
    if (pressSeen != 0) begin
      errors++;
      $display("[TB] FAIL single_press: %0d extra pulses required 0", pressSeen);
    end
    waitEval();
    keys = '0;
    lat = 0;
    do begin tick(); lat++; end while (kp.release_pulse !== 1'b1 && lat < 120);
    checks++;
    if (kp.release_pulse !== 1'b1 || lat < 51 || lat > 68) begin
      errors++;
      $display("[TB] FAIL release_latency: %0d cycles (pulse=%b) required 51..68", lat, kp.release_pulse);
    end
    tick();
    checks++;
    if (kp.key_code !== 4'd6 || kp.key_down !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_state: code=%0d down=%b required 6/0", kp.key_code, kp.key_down);
    end
  endtask

  task automatic test_glitch();
    waitEval();
    keys[6] = 1'b1;
    waitEval();
    keys = '0;
    clearSeen();
    repeat (5) waitEval();
    checks++;
    if (pressSeen != 0 || kp.key_down !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_reject: presses=%0d down=%b required 0/0", pressSeen, kp.key_down);
    end
  endtask

  task automatic test_multi();
    int n;
    waitEval();
    keys = 16'h0001;
    n = 0;
    do begin tick(); n++; end while (kp.press_pulse !== 1'b1 && n < 120);
    checks++;
    if (kp.press_pulse !== 1'b1 || kp.key_code !== 4'd0) begin
      errors++;
      $display("[TB] FAIL key0_commit: pulse=%b code=%0d required 1/0", kp.press_pulse, kp.key_code);
    end
    waitEval();
    keys = 16'h0021;
    waitEval();
    tick();
    checks++;
    if (kp.multi_key !== 1'b1) begin
      errors++;
      $display("[TB] FAIL multi_set: multi_key=%b required 1", kp.multi_key);
    end
    clearSeen();
    repeat (34) tick();
    checks++;
    if (pressSeen != 0 || relSeen != 0 || kp.key_code !== 4'd0 || kp.key_down !== 1'b1) begin
      errors++;
      $display("[TB] FAIL multi_hold: pr=%0d rel=%0d code=%0d down=%b required 0/0/0/1",
               pressSeen, relSeen, kp.key_code, kp.key_down);
    end
    waitEval();
    keys = 16'h0001;
    clearSeen();
    waitEval();
    tick();
    checks++;
    if (kp.multi_key !== 1'b0 || pressSeen != 0 || relSeen != 0) begin
      errors++;
      $display("[TB] FAIL multi_clear: multi_key=%b pr=%0d rel=%0d required 0/0/0", kp.multi_key, pressSeen, relSeen);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    waitEval();
    keys = 16'h0008;
    n = 0;
    do begin tick(); n++; end while (!(kp.key_down === 1'b1 && kp.key_code === 4'd3) && n < 150);
    checks++;
    if (kp.key_code !== 4'd3 || kp.key_down !== 1'b1) begin
      errors++;
      $display("[TB] FAIL key3_commit: code=%0d down=%b required 3/1", kp.key_code, kp.key_down);
    end
    waitEval();
    keys = 16'h1000;
    n = 0;
    do begin tick(); n++; end while (kp.release_pulse !== 1'b1 && n < 120);
    checks++;
    if (kp.release_pulse !== 1'b1 || kp.press_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL swap_release: rel=%b pr=%b required 1/0", kp.release_pulse, kp.press_pulse);
    end
    tick();
    checks++;
    if (kp.press_pulse !== 1'b1 || kp.release_pulse !== 1'b0 || kp.key_code !== 4'd12) begin
      errors++;
      $display("[TB] FAIL swap_press: pr=%b rel=%b code=%0d required 1/0/12",
               kp.press_pulse, kp.release_pulse, kp.key_code);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    waitEval();
    keys = 16'h0040;
    n = 0;
    do begin tick(); n++; end while (!(kp.key_down === 1'b1 && kp.key_code === 4'd6) && n < 150);
    repeat ($urandom_range(0, 16)) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({kp.col_n, kp.key_code, kp.key_down, kp.press_pulse, kp.release_pulse, kp.multi_key} !== {4'hF, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_mid: col_n=%b code=%0d down=%b pr=%b rel=%b multi=%b required 1111/0",
               kp.col_n, kp.key_code, kp.key_down, kp.press_pulse, kp.release_pulse, kp.multi_key);
    end
    clearSeen();
    keys = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) waitEval();
    checks++;
    if (relSeen != 0 || pressSeen != 0 || kp.key_down !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_release: rel=%0d pr=%0d down=%b required 0/0/0", relSeen, pressSeen, kp.key_down);
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int n;
    int expGap [3] = '{34, 17, 17};
    waitEval();
    keys = 16'h0040;
    n = 0;
    do begin tick(); n++; end while (kp.press_pulse !== 1'b1 && n < 120);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin tick(); n++; end while (kp.press_pulse !== 1'b1 && n < 60);
      checks++;
      if (kp.press_pulse !== 1'b1 || n != expGap[i] || kp.key_code !== 4'd6) begin
        errors++;
        $display("[TB] FAIL repeat_gap %0d: %0d cycles code=%0d required %0d cycles code 6",
                 i, n, kp.key_code, expGap[i]);
      end
    end
    waitEval();
    keys = '0;
  endtask
`endif

  // Frame-level reference state
  int mPrevKind, mPrevCode, mCnt, mComCode, mKeyCode, mRepCnt;
  bit mCom, mKeyDown, mMulti, mRepArmed;
  int expPress, expRel;
  bit expSwap;

  task automatic modelFrame(input logic [15:0] k);
    int kind, code;
    bit commit;
    kind = ($countones(k) == 0) ? 0 : (($countones(k) == 1) ? 1 : 2);
    code = 0;
    for (int i = 0; i < 16; i++) if (k[i]) code = i;
    expPress = 0; expRel = 0; expSwap = 1'b0; commit = 1'b0;
    mMulti = (kind == 2);
    if (kind == 2) begin
      mCnt = 0;
      mPrevKind = 2;
    end else begin
      if (kind == mPrevKind && (kind == 0 || code == mPrevCode)) mCnt = (mCnt < DEB) ? mCnt + 1 : DEB;
      else mCnt = 1;
      mPrevKind = kind;
      mPrevCode = code;
      commit = (mCnt == DEB) && ((kind == 0) ? mCom : (!mCom || code != mComCode));
    end
    if (commit) begin
      if (kind == 1) begin
        expPress = 1;
        if (mCom) begin expRel = 1; expSwap = 1'b1; end
        mCom = 1'b1; mComCode = code; mKeyCode = code; mKeyDown = 1'b1;
      end else begin
        expRel = 1;
        mCom = 1'b0; mKeyDown = 1'b0;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    if (commit || kind == 2) begin
      mRepCnt = 0; mRepArmed = 1'b0;
    end else if (mCom) begin
      mRepCnt++;
      if ((!mRepArmed && mRepCnt == 2) || (mRepArmed && mRepCnt == 1)) begin
        expPress++;
        mRepCnt = 0;
        mRepArmed = 1'b1;
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [15:0] cur, nxt;
    int runLeft, a, b, sel;
    applyReset();
    mPrevKind = 0; mPrevCode = 0; mCnt = 0; mCom = 1'b0; mComCode = 0;
    mKeyCode = 0; mKeyDown = 1'b0; mMulti = 1'b0; mRepCnt = 0; mRepArmed = 1'b0;
    cur = '0; nxt = '0; runLeft = 0;
    for (int f = 0; f < 150; f++) begin
      waitEval();
      if (f > 0) begin
        checks++;
        if (pressSeen != expPress || relSeen != expRel || swapSeen != int'(expSwap) || overlapSeen != 0) begin
          errors++;
          $display("[TB] FAIL rand_pulses frame %0d: pr=%0d rel=%0d swap=%0d ovl=%0d required %0d/%0d/%0d/0",
                   f, pressSeen, relSeen, swapSeen, overlapSeen, expPress, expRel, expSwap);
        end
        checks++;
        if (kp.key_down !== mKeyDown || kp.key_code !== 4'(mKeyCode) || kp.multi_key !== mMulti) begin
          errors++;
          $display("[TB] FAIL rand_state frame %0d: down=%b code=%0d multi=%b required %b/%0d/%b",
                   f, kp.key_down, kp.key_code, kp.multi_key, mKeyDown, mKeyCode, mMulti);
        end
      end
      modelFrame(cur);
      if (runLeft == 0) begin
        sel = $urandom_range(0, 9);
        a   = $urandom_range(0, 15);
        b   = (a + 1 + $urandom_range(0, 14)) % 16;
        if (sel < 3) nxt = '0;
        else if (sel < 8) nxt = 16'(1) << a;
        else nxt = (16'(1) << a) | (16'(1) << b);
        runLeft = $urandom_range(1, 5);
      end
      runLeft--;
      clearSeen();
      keys = nxt;
      cur  = nxt;
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_multi();
    test_back_to_back();
    test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised ROWS x COLS matrix keypad scanner with a programmable column dwell time, a frame-level debouncer and multi-key (ghost) rejection.
- Emits a registered key code, a held-key level, and one-cycle press and release pulses for the front-panel control logic.
- Succeeds the fixed 4x4 scanner. Adds arbitrary matrix size, scan pacing, debounce, release events and ghost detection.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column drive outputs (2..8)
SCAN_DIV, 1000, clk cycles each column is driven (dwell); minimum 4
DEBOUNCE, 3, consecutive identical frame results required before commit (1..15)
REPEAT_DELAY, 50, frames held before first auto-repeat (KEYPAD_REPEAT_EN only)
REPEAT_RATE, 10, frames between subsequent auto-repeats (KEYPAD_REPEAT_EN only)
KW, $clog2(ROWS*COLS), key code width (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
row_n  input  ROWS  keypad rows, active-low, externally pulled up, asynchronous to clk
col_n  output  COLS  column drive, active-low, one-hot-low while scanning
key_code  output  KW  committed key = row_idx*COLS + col_idx
key_down  output  1  level: a debounced key is currently held
press_pulse  output  1  one-cycle pulse when key_code becomes valid (and on each repeat)
release_pulse  output  1  one-cycle pulse when the committed key is released
multi_key  output  1  level: the most recent frame saw two or more closed switches

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. While reset is high, all outputs hold their reset values: col_n=all ones, key_code=0, key_down=0, press_pulse=0, release_pulse=0, multi_key=0. All counters, the synchroniser and the debounce state clear.
- Synchroniser: row_n passes through a 2-flop synchroniser before any use.
- Scan FSM (SCAN, EVAL):
  - SCAN drives column c (col_n bit c low, all others high) for SCAN_DIV cycles. The synchronised rows are sampled on the last dwell cycle, then c increments.
  - After column COLS-1 is sampled, the FSM enters EVAL for exactly 1 cycle (col_n=all ones), then returns to SCAN with c=0.
  - Frame length = COLS*SCAN_DIV+1 cycles. Scanning starts at column 0 on the first clk after reset deasserts.
- Frame result:
  - NONE: no sampled row bit is low.
  - SINGLE(code): exactly one bit is low across the whole frame.
  - MULTI: two or more bits are low.
- multi_key updates in EVAL: 1 if the frame result is MULTI, else 0.
- Debounce, evaluated in EVAL:
  - A MULTI result resets the match counter and leaves the committed state untouched.
  - Otherwise, a result equal to the previous frame's result increments a saturating counter; a different result loads the counter with 1.
  - When the counter reaches DEBOUNCE and the result differs from the committed state, the result is committed.
- Commit actions, registered, effective the cycle after EVAL:
  - NONE -> SINGLE(k): key_code=k, key_down=1, press_pulse=1 for one cycle.
  - SINGLE(k) -> NONE: key_down=0, release_pulse=1 for one cycle; key_code keeps k.
  - SINGLE(k) -> SINGLE(j): release_pulse in cycle 1; key_code=j and press_pulse in cycle 2. Pulses never overlap.
- Pulse latency: a press that is clean from the start of a frame yields press_pulse DEBOUNCE frames later, at most +1 frame for phase alignment.
- Reset mid-operation: all state clears immediately; no release_pulse is generated for a key held at reset.

Optional Feature:
- KEYPAD_REPEAT_EN defined:
  - While a committed SINGLE key stays committed, a frame counter runs.
  - press_pulse re-fires (key_code unchanged) after REPEAT_DELAY frames, then every REPEAT_RATE frames.
  - The counter clears on any commit or on a MULTI frame.
- KEYPAD_REPEAT_EN undefined: exactly one press_pulse per commit; REPEAT_* parameters are ignored and no repeat logic is synthesised.

Test Plan:
- Config ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, frame=17 cycles. Reset release -> col_n cycles 1110,1101,1011,0111, each held 4 cycles, then 1111 for 1 cycle; all outputs 0.
- Hold row 1/col 2 closed (row_n bit1 low while col_n bit2 low) -> key_code=6 with a single press_pulse 51..68 cycles after closure; key_down=1. Open switch -> release_pulse after 3 frames, key_down=0, key_code stays 6.
- Close key 6 for only 1 frame, then open -> no press_pulse, key_down stays 0.
- Hold key 0 until committed, then add key 5 -> multi_key=1 within 1 frame, no pulses, key_code stays 0 with key_down=1. Remove key 5 -> multi_key=0.
- Switch directly from key 3 to key 12 -> release_pulse, next cycle press_pulse with key_code=12.
- Assert reset while key 6 is committed -> all outputs 0 immediately, no release_pulse. With KEYPAD_REPEAT_EN, REPEAT_DELAY=2, REPEAT_RATE=1 and key held -> press_pulse repeats at 2 frames, then every frame.
